// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - resolved-branch, predictor-update and redirect signals
// slave is the branch resolve unit's view; master is the commit/fetch/predictor side.
interface branch_resolve_unit_if;
  logic        br_valid_in;
  logic [31:0] br_pc_in;
  logic        br_pred_taken_in;
  logic        br_taken_in;
  logic [31:0] br_target_in;
  logic        br_ready_out;
  logic        upd_valid_out;
  logic [31:0] upd_pc_out;
  logic        upd_result_out;
  logic        upd_ready_in;
  logic        flush_out;
  logic [31:0] flush_pc_out;

  modport slave (
    input  br_valid_in, br_pc_in, br_pred_taken_in, br_taken_in, br_target_in, upd_ready_in,
    output br_ready_out, upd_valid_out, upd_pc_out, upd_result_out, flush_out, flush_pc_out
  );

  modport master (
    output br_valid_in, br_pc_in, br_pred_taken_in, br_taken_in, br_target_in, upd_ready_in,
    input  br_ready_out, upd_valid_out, upd_pc_out, upd_result_out, flush_out, flush_pc_out
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - mispredict redirect plus predictor training FIFO
// Optional BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int QDEPTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  branch_resolve_unit_if.slave bus
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]          stat_branches_out,
  output logic [31:0]          stat_mispredicts_out
`endif
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(QDEPTH);

  logic [31:0]   pc_mem_q  [QDEPTH];
  logic          res_mem_q [QDEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          flush_q, flush_d;
  logic [31:0]   flush_pc_q, flush_pc_d;

  logic br_ready, upd_valid, accept, pop, mispredict;

  // Readiness looks only at the registered count, so a full queue refuses even when popping.
  assign br_ready   = (count_q != CNT_FULL);
  assign upd_valid  = (count_q != '0);
  assign accept     = bus.br_valid_in && br_ready && rdy_in;
  assign pop        = upd_valid && bus.upd_ready_in && rdy_in;
  assign mispredict = (bus.br_pred_taken_in != bus.br_taken_in);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;
    if (rdy_in) begin
      flush_d = accept && mispredict;
      if (accept && mispredict)
        flush_pc_d = bus.br_taken_in ? bus.br_target_in : bus.br_pc_in + 32'd4;
      if (accept) tail_d = tail_q + 1'b1;
      if (pop)    head_d = head_q + 1'b1;
      case ({accept, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Storage needs no reset: entries are only visible while count says they are valid.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      pc_mem_q[tail_q]  <= bus.br_pc_in;
      res_mem_q[tail_q] <= bus.br_taken_in;
    end
  end

  assign bus.br_ready_out   = br_ready;
  assign bus.upd_valid_out  = upd_valid;
  assign bus.upd_pc_out     = pc_mem_q[head_q];
  assign bus.upd_result_out = res_mem_q[head_q];
  assign bus.flush_out      = flush_q;
  assign bus.flush_pc_out   = flush_pc_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;

  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (accept && stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
    if (accept && mispredict && stat_mis_q != 32'hFFFF_FFFF) stat_mis_d = stat_mis_q + 32'd1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_branches_out    = stat_br_q;
  assign stat_mispredicts_out = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and randomized checks against a queue-based model
module tb_branch_resolve_unit;
  localparam int QDEPTH = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  branch_resolve_unit_if bus ();

`ifdef BRU_STATS_EN
  logic [31:0] stat_branches_out, stat_mispredicts_out;
  logic [31:0] m_stat_br = 0, m_stat_mis = 0;
`endif

  branch_resolve_unit #(.QDEPTH(QDEPTH)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus.slave)
`ifdef BRU_STATS_EN
    ,
    .stat_branches_out    (stat_branches_out),
    .stat_mispredicts_out (stat_mispredicts_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Model: a plain queue of {taken, pc} plus the expected redirect registers.
  logic [32:0] m_q [$];
  logic        m_flush = 1'b0;
  logic [31:0] m_flush_pc = 32'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    check("br_ready", 32'(bus.br_ready_out), 32'(m_q.size() < QDEPTH));
    check("upd_valid", 32'(bus.upd_valid_out), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("upd_pc", bus.upd_pc_out, m_q[0][31:0]);
      check("upd_result", 32'(bus.upd_result_out), 32'(m_q[0][32]));
    end
    check("flush", 32'(bus.flush_out), 32'(m_flush));
    check("flush_pc", bus.flush_pc_out, m_flush_pc);
`ifdef BRU_STATS_EN
    check("stat_branches", stat_branches_out, m_stat_br);
    check("stat_mispredicts", stat_mispredicts_out, m_stat_mis);
`endif
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic pr, input logic tk,
                      input logic [31:0] tg, input logic ur, input logic rd);
    logic acc, pop;
    bus.br_valid_in      = v;
    bus.br_pc_in         = pc;
    bus.br_pred_taken_in = pr;
    bus.br_taken_in      = tk;
    bus.br_target_in     = tg;
    bus.upd_ready_in     = ur;
    rdy_in               = rd;
    acc = v && (m_q.size() < QDEPTH) && rd;
    pop = (m_q.size() != 0) && ur && rd;
    if (rd) begin
      m_flush = acc && (pr != tk);
      if (m_flush) m_flush_pc = tk ? tg : pc + 32'd4;
    end
`ifdef BRU_STATS_EN
    if (acc && m_stat_br != 32'hFFFF_FFFF) m_stat_br++;
    if (acc && pr != tk && m_stat_mis != 32'hFFFF_FFFF) m_stat_mis++;
`endif
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back({tk, pc});
    @(posedge clk_in);
    @(negedge clk_in);
    check_all();
  endtask

  task automatic model_reset();
    m_q.delete();
    m_flush    = 1'b0;
    m_flush_pc = 32'd0;
`ifdef BRU_STATS_EN
    m_stat_br  = 0;
    m_stat_mis = 0;
`endif
  endtask

  initial begin
    bus.br_valid_in = 0; bus.br_pc_in = 0; bus.br_pred_taken_in = 0;
    bus.br_taken_in = 0; bus.br_target_in = 0; bus.upd_ready_in = 0;
    repeat (2) @(negedge clk_in);
    check_all();
    rst_in = 1'b1;
    @(negedge clk_in);
    check_all();

    // Mispredicted taken branch: redirect to target, then pulse drops.
    step(1, 32'h1000, 0, 1, 32'h2000, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    // Not-taken mispredict at the top of the address space wraps to zero.
    step(1, 32'hFFFF_FFFC, 1, 0, 32'h1234, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);

    // Fill with correct predictions, 5th ignored, then push+pop while full.
    for (int i = 0; i < 5; i++) step(1, 32'h100 + 32'(i * 4), 1, 1, 32'h500, 0, 1);
    step(1, 32'h900, 0, 1, 32'h777, 1, 1);
    step(1, 32'h904, 0, 0, 32'h0, 1, 1);
    step(1, 32'h908, 1, 0, 32'h0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1);

    // Freeze during a flush pulse with pops pending.
    step(1, 32'h3000, 1, 1, 32'h3100, 0, 1);
    step(1, 32'h3004, 0, 1, 32'h3800, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 32'h4000, 1, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 9) < 7, pc, 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8);
    end

    // Asynchronous reset in the middle of a flush pulse with entries queued.
    step(1, 32'h5000, 0, 0, 32'h0, 0, 1);
    step(1, 32'h5004, 0, 1, 32'h6000, 0, 1);
    #2 rst_in = 1'b0;
    #1;
    model_reset();
    check("rst_upd_valid", 32'(bus.upd_valid_out), 32'd0);
    check("rst_flush", 32'(bus.flush_out), 32'd0);
    check("rst_br_ready", 32'(bus.br_ready_out), 32'd1);
    @(negedge clk_in);
    rst_in = 1'b1;
    check_all();
    step(1, 32'h7000, 1, 0, 32'h0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
